// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetch stage of the 5-stage RISC-V core. Owns the program counter and
//   issues one word request at a time over a req/gnt/rvalid handshake. Each
//   fetched word is delivered as {pc_out, instruction_out, valid_out} to the
//   IF/ID register. Honours hazard stalls and EX-stage redirects, and drops
//   any response that belongs to a squashed fetch.
//
//   Optional feature: define FETCH_MISALIGN_CHECK_EN to flag redirect targets
//   with [1:0] != 0 (sticky misaligned_out) and halt fetching until reset.
//   Without it, redirect targets are forced to word alignment.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-low reset
//   imem_req/imem_addr    fetch request and its byte address (decoded from
//                         registered state only)
//   imem_gnt              memory accepts the request this cycle
//   imem_rvalid/rdata     read response
//   stall                 hazard unit: hold fetch outputs
//   redirect/redirect_pc  EX-stage taken branch/jump and its target
//   pc_out/instruction_out/valid_out  delivered instruction (valid 0 = bubble)
//   misaligned_out        sticky misaligned-target flag
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out,
  output logic        misaligned_out
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_HALT
  } state_e;

  state_e      state_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] hold_pc_q;
  logic [31:0] hold_instr_q;
  logic [31:0] pc_out_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic        mis_q;
  logic        halt_pend_q;

  logic [31:0] pc_inc_d;
  logic [31:0] tgt_d;
  logic        tgt_bad_d;
  logic        halt_go_d;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign tgt_d     = redirect_pc;
  assign tgt_bad_d = (redirect_pc[1:0] != 2'b00);
`else
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^redirect_pc[1:0];
  assign tgt_d          = {redirect_pc[31:2], 2'b00};
  assign tgt_bad_d      = 1'b0;
`endif

  // A misaligned target this cycle, or one seen earlier while a response was
  // still outstanding, sends the FSM to HALT once nothing is in flight.
  assign halt_go_d = tgt_bad_d | halt_pend_q;
  assign pc_inc_d  = fetch_pc_q + 32'd4;

  assign imem_req        = (state_q == S_REQ);
  assign imem_addr       = fetch_pc_q;
  assign pc_out          = pc_out_q;
  assign instruction_out = instr_q;
  assign valid_out       = valid_q;
  assign misaligned_out  = mis_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_REQ;
      fetch_pc_q   <= RESET_PC;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      pc_out_q     <= '0;
      instr_q      <= '0;
      valid_q      <= 1'b0;
      mis_q        <= 1'b0;
      halt_pend_q  <= 1'b0;
    end else begin
      // Output register: bubble unless something is delivered below; a
      // stall freezes all three outputs.
      if (!stall) begin
        valid_q <= 1'b0;
      end

      if (redirect && (state_q != S_HALT)) begin
        valid_q    <= 1'b0;
        fetch_pc_q <= tgt_d;
        if (tgt_bad_d) begin
          mis_q       <= 1'b1;
          halt_pend_q <= 1'b1;
        end
        case (state_q)
          // A grant in the same cycle leaves a response in flight to drop.
          S_REQ: begin
            if (imem_gnt) begin
              state_q <= S_DRAIN;
            end else begin
              state_q <= halt_go_d ? S_HALT : S_REQ;
            end
          end
          S_WAIT, S_DRAIN: begin
            if (imem_rvalid) begin
              state_q <= halt_go_d ? S_HALT : S_REQ;
            end else begin
              state_q <= S_DRAIN;
            end
          end
          default: begin
            state_q <= halt_go_d ? S_HALT : S_REQ;
          end
        endcase
      end else begin
        case (state_q)
          S_REQ: begin
            if (imem_gnt) begin
              state_q <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              fetch_pc_q <= pc_inc_d;
              if (stall) begin
                hold_pc_q    <= fetch_pc_q;
                hold_instr_q <= imem_rdata;
                state_q      <= S_HOLD;
              end else begin
                pc_out_q <= fetch_pc_q;
                instr_q  <= imem_rdata;
                valid_q  <= 1'b1;
                state_q  <= S_REQ;
              end
            end
          end
          S_HOLD: begin
            if (!stall) begin
              pc_out_q <= hold_pc_q;
              instr_q  <= hold_instr_q;
              valid_q  <= 1'b1;
              state_q  <= S_REQ;
            end
          end
          S_DRAIN: begin
            if (imem_rvalid) begin
              state_q <= halt_pend_q ? S_HALT : S_REQ;
            end
          end
          default: begin
            state_q <= S_HALT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;
  logic        misaligned_out;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out),
    .misaligned_out  (misaligned_out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Memory behaviour
  int          gnt_pct;
  int          lat_fix;   // 0 = random latency 1..3
  int          spur_pct;  // stray rvalid while nothing is outstanding
  int          mem_cnt;
  logic [31:0] mem_addr;

  // Reference model: expected fetch address, in-flight fetch, queue of
  // fetched-but-undelivered instructions, and the expected output register.
  logic [31:0] next_addr;
  bit          outstanding;
  bit          squashed;
  logic [31:0] out_addr;
  logic [31:0] q_pc[$];
  logic [31:0] q_ins[$];
  bit          halt_m;
  bit          mis_m;
  bit          exp_valid;
  logic [31:0] exp_pc;
  logic [31:0] exp_ins;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h1111_1111;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    next_addr   = 32'h0;
    outstanding = 0;
    squashed    = 0;
    out_addr    = '0;
    q_pc.delete();
    q_ins.delete();
    halt_m      = 0;
    mis_m       = 0;
    exp_valid   = 0;
    exp_pc      = '0;
    exp_ins     = '0;
    mem_cnt     = 0;
    mem_addr    = '0;
  endtask

  // One clock: choose memory responses, advance the model over the coming
  // edge, drive the inputs, then compare outputs 1 time unit after the edge.
  task automatic step(input bit s, input bit r, input logic [31:0] t);
    bit          g;
    bit          v;
    bit          real_v;
    bit          exp_req;
    logic [31:0] d;
    logic [31:0] tt;
    real_v = 0;
    v      = 0;
    d      = $urandom;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        real_v = 1;
        v      = 1;
        d      = mem_word(mem_addr);
      end
    end else if ($urandom_range(99) < spur_pct) begin
      v = 1;
    end
    g = (mem_cnt == 0) && !real_v && ($urandom_range(99) < gnt_pct);
    if (g && imem_req) begin
      mem_cnt     = (lat_fix != 0) ? lat_fix : int'($urandom_range(3, 1));
      mem_addr    = imem_addr;
      outstanding = 1;
      squashed    = 0;
      out_addr    = next_addr;
    end
    if (real_v) begin
      if (!squashed && !r) begin
        q_pc.push_back(out_addr);
        q_ins.push_back(mem_word(out_addr));
        next_addr = out_addr + 32'd4;
      end
      outstanding = 0;
    end
    if (r) begin
      tt = t;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (t[1:0] != 2'b00) begin
        mis_m  = 1;
        halt_m = 1;
      end
`else
      tt[1:0] = 2'b00;
`endif
      next_addr = tt;
      q_pc.delete();
      q_ins.delete();
      if (outstanding) squashed = 1;
      exp_valid = 0;
    end else if (!s) begin
      if (q_pc.size() > 0) begin
        exp_valid = 1;
        exp_pc    = q_pc.pop_front();
        exp_ins   = q_ins.pop_front();
      end else begin
        exp_valid = 0;
      end
    end

    stall       = s;
    redirect    = r;
    redirect_pc = t;
    imem_gnt    = g;
    imem_rvalid = v;
    imem_rdata  = d;
    @(posedge clk);
    #1;
    chk("valid_out", {31'b0, valid_out}, {31'b0, exp_valid});
    chk("pc_out", pc_out, exp_pc);
    chk("instruction_out", instruction_out, exp_ins);
    chk("misaligned_out", {31'b0, misaligned_out}, {31'b0, mis_m});
    exp_req = !outstanding && (q_pc.size() == 0) && !halt_m;
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, next_addr);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, {31'b0, valid_out}, 32'd0);
    chk({tag, "_pc"}, pc_out, 32'd0);
    chk({tag, "_instr"}, instruction_out, 32'd0);
    chk({tag, "_mis"}, {31'b0, misaligned_out}, 32'd0);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'd1);
    chk({tag, "_addr"}, imem_addr, 32'd0);
  endtask

  initial begin
    bit          s;
    bit          r;
    logic [31:0] t;
    rst = 1'b0;
    stall = 0; redirect = 0; redirect_pc = '0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    gnt_pct = 100; lat_fix = 1; spur_pct = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    @(negedge clk);
    rst = 1'b1;

    // Back-to-back fetch, single-cycle memory
    step(0, 0, '0);
    step(0, 0, '0);
    chk("first_pc", pc_out, 32'h0);
    chk("first_instr", instruction_out, 32'h1111_1111);
    chk("first_next_addr", imem_addr, 32'h4);
    step(0, 0, '0);

    // Stall while pc 4 returns: held in buffer, no requests
    step(1, 0, '0);
    step(1, 0, '0);
    step(1, 0, '0);
    chk("stall_pc_frozen", pc_out, 32'h0);
    chk("stall_no_req", {31'b0, imem_req}, 32'd0);
    step(0, 0, '0);
    chk("unstall_pc", pc_out, 32'h4);
    chk("unstall_instr", instruction_out, 32'h2222_2222);
    chk("unstall_next_addr", imem_addr, 32'h8);

    // Redirect while waiting on pc 8; its response arrives a cycle later
    lat_fix = 2;
    step(0, 0, '0);
    step(0, 1, 32'h40);
    chk("redir_valid", {31'b0, valid_out}, 32'd0);
    lat_fix = 1;
    step(0, 0, '0);
    chk("redir_addr", imem_addr, 32'h40);
    step(0, 0, '0);
    step(0, 0, '0);
    chk("redir_pc", pc_out, 32'h40);

    // Redirect together with stall
    gnt_pct = 0;
    step(1, 1, 32'h100);
    chk("redir_stall_valid", {31'b0, valid_out}, 32'd0);
    chk("redir_stall_addr", imem_addr, 32'h100);
    gnt_pct = 100;
    step(0, 0, '0);
    step(0, 0, '0);
    chk("redir_stall_pc", pc_out, 32'h100);

    // Wrap of the fetch address
    gnt_pct = 0;
    step(0, 1, 32'hFFFF_FFFC);
    gnt_pct = 100;
    step(0, 0, '0);
    step(0, 0, '0);
    chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
    chk("wrap_next_addr", imem_addr, 32'h0);

    // Randomised traffic
    gnt_pct = 60; lat_fix = 0; spur_pct = 5;
    for (int i = 0; i < 2000; i++) begin
      s = ($urandom_range(99) < 25);
      r = ($urandom_range(99) < 6);
      case ($urandom_range(2))
        0:       t = $urandom & 32'h0000_0FFF;
        1:       t = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        default: t = $urandom;
      endcase
`ifdef FETCH_MISALIGN_CHECK_EN
      t[1:0] = 2'b00;
`endif
      step(s, r, t);
    end
    spur_pct = 0;
    for (int i = 0; i < 20; i++) step(0, 0, '0);

    // Misaligned redirect target, issued from the REQ state
    gnt_pct = 0;
    for (int i = 0; i < 10 && !imem_req; i++) step(0, 0, '0);
    chk("pre_mis_req", {31'b0, imem_req}, 32'd1);
    step(0, 1, 32'h42);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_flag", {31'b0, misaligned_out}, 32'd1);
    gnt_pct = 100;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, '0);
      chk("halt_no_req", {31'b0, imem_req}, 32'd0);
    end
`else
    chk("mis_forced_addr", imem_addr, 32'h40);
    chk("mis_flag_off", {31'b0, misaligned_out}, 32'd0);
    gnt_pct = 100; lat_fix = 1;
    step(0, 0, '0);
    step(0, 0, '0);
    chk("mis_forced_pc", pc_out, 32'h40);
`endif

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    reset_checks("async_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    gnt_pct = 100; lat_fix = 1;
    step(0, 0, '0);
    step(0, 0, '0);
    chk("post_reset_pc", pc_out, 32'h0);
    chk("post_reset_instr", instruction_out, 32'h1111_1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage of the 5-stage RISC-V core. Owns the program counter, issues one-at-a-time word requests to instruction memory over a req/gnt/rvalid handshake, and delivers each {pc, instruction, valid} triple to the IF/ID pipeline register. Honours hazard-unit stalls and branch/jump redirects from EX, discarding any response that belongs to a squashed fetch.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be 4-byte aligned.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch word address (byte address, [1:0]=00)
- imem_gnt  in  1  memory accepts request this cycle (qualified by imem_req)
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  instruction word
- stall  in  1  hazard unit: hold fetch outputs
- redirect  in  1  EX-stage taken branch/jump
- redirect_pc  in  32  redirect target
- pc_out  out  32  pc of delivered instruction
- instruction_out  out  32  delivered instruction
- valid_out  out  1  pc_out/instruction_out hold a real instruction (0 = bubble)
- misaligned_out  out  1  sticky misaligned-target flag (see Configuration)

## Operation
- Registers: fetch_pc, state, one-entry holding buffer (hold_pc, hold_instr), output register.
- States: REQ, WAIT, HOLD, DRAIN, HALT.
- REQ: imem_req=1, imem_addr=fetch_pc. gnt -> WAIT.
- WAIT: on rvalid, with stall=0: output <= {fetch_pc, rdata, 1}, fetch_pc += 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0), -> REQ. With stall=1: capture into hold buffer, fetch_pc += 4, -> HOLD.
- HOLD: no request. When stall drops: output <= hold buffer, valid=1, -> REQ.
- Output register: when stall=1 all three outputs hold; when stall=0 and nothing delivered this cycle, valid_out<=0 (pc_out/instruction_out hold last value).
- Redirect (highest priority, overrides stall): fetch_pc <= redirect_pc, valid_out <= 0, hold buffer discarded. Next state: REQ if no fetch outstanding; DRAIN if in WAIT without rvalid this cycle, or in REQ with gnt this cycle. Redirect in WAIT with rvalid same cycle: response dropped, -> REQ.
- DRAIN: imem_req=0; response on rvalid dropped, -> REQ. Redirect during DRAIN updates fetch_pc, stays DRAIN (or -> REQ if rvalid same cycle).
- At most one outstanding request at any time; rvalid outside WAIT/DRAIN ignored.

## Timing
- Reset (rst=0, async): state=REQ, fetch_pc=RESET_PC, valid_out=0, pc_out=0, instruction_out=0, misaligned_out=0, hold buffer cleared. imem_req=1 on first edge after release.
- imem_req/imem_addr decoded from registered state/fetch_pc only (no input-to-output comb path).
- gnt in cycle N -> WAIT at N+1; rvalid earliest at N+1.
- rvalid at cycle M (stall=0) -> valid_out=1 at M+1, next imem_req at M+1. Peak throughput: 1 instruction / 2 cycles with single-cycle memory.
- Redirect at cycle R -> valid_out=0 at R+1; first request to redirect_pc at R+1 (no outstanding) or one cycle after dropped rvalid.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 sets misaligned_out=1 (sticky), valid_out<=0, -> HALT after any outstanding response is dropped; HALT issues no requests until reset.
- Undefined: redirect_pc[1:0] forced to 00, misaligned_out tied 0, HALT unreachable.

## Test plan
- Reset, RESET_PC=0, memory gnt immediate, rvalid 1 cycle later returning 0x1111_1111/0x2222_2222/0x3333_3333 -> outputs (0,0x1111_1111),(4,0x2222_2222),(8,0x3333_3333), valid_out pulses every 2 cycles.
- stall=1 for 3 cycles while rvalid returns 0x2222_2222 at pc 4 -> outputs frozen on pc 0, no imem_req during HOLD; stall drop -> pc_out=4 next cycle, then request to 8.
- redirect to 0x40 while in WAIT for pc 8, rvalid one cycle later -> response dropped, valid_out=0, next imem_addr=0x40, pc_out=0x40 delivered.
- redirect to 0x100 with stall=1 same cycle -> valid_out=0 next cycle, fetch resumes at 0x100.
- fetch_pc=0xFFFF_FFFC -> next request address 0x0000_0000.
- Macro defined, redirect_pc=0x42 -> misaligned_out=1, imem_req stays 0 until rst asserted low; macro undefined -> fetch from 0x40, misaligned_out=0.
